// File: rtl/wallace_acc_pkg.sv
// Shared types and widths for the Wallace dot-product accumulator.
package wallace_acc_pkg;

  localparam int OP_W   = 6;
  localparam int PROD_W = 12;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/top_level_multiplier.sv
// 6x6 unsigned Wallace-tree multiplier: partial-product rows are reduced with
// carry-save layers (6 -> 4 -> 3 -> 2) and resolved by one final adder.
module top_level_multiplier
  import wallace_acc_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Product
);

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Bits shifted past PROD_W are dropped; the true product always fits in PROD_W.
  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [PROD_W-1:0] pp [OP_W];

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = PROD_W'(A & {OP_W{B[i]}}) << i;
    end
  end

  logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3;

  assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
  assign c0 = csa_carry(pp[0], pp[1], pp[2]);
  assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
  assign c1 = csa_carry(pp[3], pp[4], pp[5]);

  assign s2 = csa_sum  (s0, c0, s1);
  assign c2 = csa_carry(s0, c0, s1);

  assign s3 = csa_sum  (s2, c2, c1);
  assign c3 = csa_carry(s2, c2, c1);

  assign Product = s3 + c3;

endmodule

// File: rtl/wallace_dot_accumulator.sv
// Streaming dot-product stage: registers operand pairs into the Wallace
// multiplier, accumulates products until a last beat, then holds the result.
module wallace_dot_accumulator
  import wallace_acc_pkg::*;
#(
  parameter int ACC_W = 16,  // must be >= PROD_W
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_a,
  input  logic [5:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Handshakes: a beat or result moves only on a rising edge where valid and
  // ready are both high; the sender must hold its payload stable until then.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic              s1_last;
  logic              s1_valid;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [ACC_W:0]    acc_sum;
  logic              in_fire;

  // A pending last beat in stage 1 blocks the next packet until DONE is left.
  assign in_ready = !rst && (state == RUN) && !(s1_valid && s1_last);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
    end
  end

  top_level_multiplier u_mult (
    .A       (s1_a),
    .B       (s1_b),
    .Product (product)
  );

  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(product);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (s1_valid) begin
            acc   <= acc_sum[ACC_W-1:0];
            ovf   <= ovf | acc_sum[ACC_W];
            count <= (count == CNT_MAX) ? count : count + 1'b1;
            if (s1_last) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= RUN;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule
